// File: rtl/uart_msg_sender_if.sv
// uart_msg_sender_if: control, ROM and UART TX signals of the message sender
interface uart_msg_sender_if #(
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 6
);
  logic              start;
  logic [SEL_W-1:0]  msg_sel;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              txempty;
  logic [7:0]        txdata;
  logic              ldtxdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  sent_cnt;
  modport slave (
    input  start, msg_sel, abort, rom_data, txempty,
    output rom_addr, txdata, ldtxdata, busy, done, err, sent_cnt
  );
  modport master (
    output start, msg_sel, abort, rom_data, txempty,
    input  rom_addr, txdata, ldtxdata, busy, done, err, sent_cnt
  );
endinterface

// File: rtl/uart_msg_sender.sv
// uart_msg_sender: streams a zero-terminated ROM message (optionally plus CR/LF) into a UART TX
module uart_msg_sender #(
  parameter int NUM_MSGS    = 4,
  parameter int MAX_LEN     = 32,
  parameter int APPEND_CRLF = 1
) (
  input logic             clk,
  input logic             rst_n,
  uart_msg_sender_if.slave bus
);
  localparam int SEL_W  = NUM_MSGS > 1 ? $clog2(NUM_MSGS) : 1;
  localparam int ADDR_W = NUM_MSGS * MAX_LEN > 1 ? $clog2(NUM_MSGS * MAX_LEN) : 1;
  localparam int IDX_W  = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W  = $clog2(MAX_LEN + 3);
  typedef enum logic [3:0] {IDLE, FETCH, ROMWAIT, LOAD, WAITLOAD, WAITSEND, CR, LF, FINISH} state_t;
  typedef enum logic [1:0] {PH_BODY, PH_CR, PH_LF} phase_t;
  localparam state_t TERM = APPEND_CRLF != 0 ? CR : FINISH;
  state_t            r_state, w_next;
  phase_t            r_phase;
  logic [SEL_W-1:0]  r_sel;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_byte, r_txdata;
  logic [ADDR_W-1:0] r_rom_addr, w_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ld, r_busy, r_done, r_err;
  logic              w_sel_ok, w_last, w_accept, w_ld, w_step, w_abort;
  assign w_sel_ok = 32'(bus.msg_sel) < NUM_MSGS;
  assign w_last   = r_idx == IDX_W'(MAX_LEN - 1);
  assign w_abort  = r_state != IDLE && bus.abort;
  assign w_accept = r_state == IDLE && bus.start && w_sel_ok;
  assign w_ld     = r_state == LOAD && !w_abort;
  assign w_step   = r_state == WAITSEND && bus.txempty && r_phase == PH_BODY && !w_abort;
  assign w_addr   = ADDR_W'(32'(r_sel) * MAX_LEN + 32'(r_idx));
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = IDLE;
    else
      case (r_state)
        IDLE:     w_next = w_accept ? FETCH : IDLE;
        FETCH:    w_next = ROMWAIT;
        ROMWAIT:  w_next = bus.rom_data != 8'h00 ? LOAD : TERM;
        LOAD:     w_next = WAITLOAD;
        WAITLOAD: w_next = WAITSEND;
        WAITSEND: if (bus.txempty)
                    w_next = r_phase == PH_CR ? LF : r_phase == PH_LF ? FINISH : w_last ? TERM : FETCH;
        CR:       w_next = LOAD;
        LF:       w_next = LOAD;
        default:  w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= '0;
      r_idx      <= '0;
      r_phase    <= PH_BODY;
      r_byte     <= '0;
      r_rom_addr <= '0;
      r_txdata   <= '0;
      r_ld       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_busy     <= w_next != IDLE;
      r_done     <= w_next == FINISH;
      r_err      <= r_state == IDLE && bus.start && !w_sel_ok;
      r_ld       <= w_ld;
      r_txdata   <= w_ld ? r_byte : 8'h00;
      r_cnt      <= w_accept ? '0 : r_cnt + CNT_W'(w_ld);
      r_idx      <= w_accept ? '0 : r_idx + IDX_W'(w_step);
      r_sel      <= w_accept ? bus.msg_sel : r_sel;
      r_phase    <= w_accept ? PH_BODY : r_state == CR ? PH_CR : r_state == LF ? PH_LF : r_phase;
      r_rom_addr <= r_state == FETCH ? w_addr : r_rom_addr;
      r_byte     <= r_state == ROMWAIT ? bus.rom_data : r_state == CR ? 8'h0D : r_state == LF ? 8'h0A : r_byte;
    end
  end
  assign bus.rom_addr = r_rom_addr;
  assign bus.txdata   = r_txdata;
  assign bus.ldtxdata = r_ld;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.sent_cnt = r_cnt;
endmodule
